// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first.
// Optional subtract mode via SERIAL_ADDER_SUB_EN (adds port 'sub').
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - request, sampled only in IDLE
//   a, b  - operands, captured on accepted start
//   sub   - (SERIAL_ADDER_SUB_EN only) 1 = a-b, captured on accept
//   busy  - high whenever not IDLE
//   done  - one-cycle result-valid pulse
//   sum   - registered result, held until next accept
//   cout  - carry out of MSB (no-borrow flag in subtract mode)
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CW-1:0]    r_count;

   logic             w_accept;
   logic             w_last;
   logic             w_x;
   logic             w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_init;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: a + ~b + 1.
   assign w_b_load = sub ? ~b : b;
   assign w_c_init = sub;
`else
   assign w_b_load = b;
   assign w_c_init = 1'b0;
`endif

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_count == LAST);

   assign w_x = r_a[0] ^ r_b[0];
   assign w_s = w_x ^ r_carry;
   assign w_c = (r_a[0] & r_b[0]) | (r_carry & w_x);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_count <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= w_b_load;
         r_sum   <= '0;
         r_carry <= w_c_init;
         r_cout  <= 1'b0;
         r_count <= '0;
      end else if (r_state == S_RUN) begin
         r_sum   <= {w_s, r_sum[WIDTH-1:1]};
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_c;
         // Hold the counter on the final bit so it never wraps.
         if (w_last) begin
            r_cout <= w_c;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Random and directed operations against an arithmetic model.
module tb_serial_adder;

   localparam int W = 8;

`ifdef SERIAL_ADDER_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_tests = 0;
   int n_fail  = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic s);
      logic [W-1:0] yn;
      yn = ~y;
      if (s) return {1'b0, x} + {1'b0, yn} + (W+1)'(1);
      return {1'b0, x} + {1'b0, y};
   endfunction

   // Runs one operation from IDLE; returns observations only.
   task automatic do_op(input  logic [W-1:0] ia,
                        input  logic [W-1:0] ib,
                        input  logic         is,
                        output logic [W-1:0] rs,
                        output logic         rc,
                        output int           lat,
                        output int           nbusy,
                        output int           ndone,
                        output logic [W-1:0] s1);
      a = ia; b = ib; sub = is; start = 1'b1;
      tick;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      lat = 0; nbusy = 0; ndone = 0;
      rs = '0; rc = 1'b0; s1 = sum;
      for (int i = 1; i <= 40; i++) begin
         if (busy) nbusy++;
         if (done) begin
            ndone++; lat = i; rs = sum; rc = cout;
         end
         if (!busy) break;
         tick;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
      repeat (2) tick;
      rst = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_busy got %b exp 0", busy); end
      n_tests++;
      if (done !== 1'b0) begin n_fail++;
         $display("FAIL reset_done got %b exp 0", done); end
      n_tests++;
      if (sum !== 8'h00) begin n_fail++;
         $display("FAIL reset_sum got %h exp 00", sum); end
      n_tests++;
      if (cout !== 1'b0) begin n_fail++;
         $display("FAIL reset_cout got %b exp 0", cout); end
   endtask

   task automatic test_directed;
      logic [W-1:0] rs, s1;
      logic rc;
      int lat, nb, nd;
      do_op(8'h35, 8'h4A, 1'b0, rs, rc, lat, nb, nd, s1);
      n_tests++;
      if (nb !== 9) begin n_fail++;
         $display("FAIL add1_busy_cycles got %0d exp 9", nb); end
      n_tests++;
      if (lat !== 9 || nd !== 1) begin n_fail++;
         $display("FAIL add1_done got lat=%0d n=%0d exp 9/1", lat, nd); end
      n_tests++;
      if ({rc, rs} !== 9'h07F) begin n_fail++;
         $display("FAIL add1_result got %b_%h exp 0_7F", rc, rs); end
      n_tests++;
      if (sum !== 8'h7F || busy !== 1'b0) begin n_fail++;
         $display("FAIL add1_hold got sum=%h busy=%b exp 7F/0", sum, busy); end
      do_op(8'hFF, 8'h01, 1'b0, rs, rc, lat, nb, nd, s1);
      n_tests++;
      if (s1 !== 8'h00) begin n_fail++;
         $display("FAIL add2_clear got %h exp 00", s1); end
      n_tests++;
      if ({rc, rs} !== 9'h100 || lat !== 9) begin n_fail++;
         $display("FAIL add2_result got %b_%h lat=%0d exp 1_00/9", rc, rs, lat); end
   endtask

   task automatic test_start_held;
      logic [W-1:0] rs;
      logic rc, b_idle, b_again;
      int first = 0;
      int lat2 = 0;
      a = 8'h80; b = 8'h80; sub = 1'b0; start = 1'b1;
      rs = '0; rc = 1'b0; b_idle = 1'b1; b_again = 1'b0;
      tick;
      for (int i = 1; i <= 11; i++) begin
         if (done && first == 0) begin
            first = i; rs = sum; rc = cout;
         end
         if (i == 10) begin
            b_idle = busy; a = 8'h03; b = 8'h04;
         end
         if (i == 11) b_again = busy;
         if (i < 11) tick;
      end
      start = 1'b0;
      a = 8'hEE; b = 8'hEE;
      n_tests++;
      if (first !== 9 || {rc, rs} !== 9'h100) begin n_fail++;
         $display("FAIL held_first got lat=%0d res=%b_%h exp 9/1_00",
                  first, rc, rs); end
      n_tests++;
      if (b_idle !== 1'b0 || b_again !== 1'b1) begin n_fail++;
         $display("FAIL held_reaccept got idle=%b again=%b exp 0/1",
                  b_idle, b_again); end
      for (int j = 1; j <= 40; j++) begin
         if (done) begin lat2 = j; rs = sum; rc = cout; end
         if (!busy) break;
         tick;
      end
      n_tests++;
      if (lat2 !== 9 || {rc, rs} !== 9'h007) begin n_fail++;
         $display("FAIL held_second got lat=%0d res=%b_%h exp 9/0_07",
                  lat2, rc, rs); end
   endtask

   task automatic test_ignore_busy;
      logic [W-1:0] rs;
      logic rc;
      int lat = 0;
      rs = '0; rc = 1'b0;
      a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick;
      start = 1'b1; a = 8'hAA; b = 8'h55;
      tick;
      start = 1'b0;
      for (int i = 4; i <= 40; i++) begin
         if (done) begin lat = i; rs = sum; rc = cout; end
         if (!busy) break;
         tick;
      end
      n_tests++;
      if (lat !== 9 || {rc, rs} !== 9'h010) begin n_fail++;
         $display("FAIL ignore_result got lat=%0d res=%b_%h exp 9/0_10",
                  lat, rc, rs); end
      tick;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++;
         $display("FAIL ignore_no_restart got busy=%b exp 0", busy); end
   endtask

   task automatic test_reset_mid;
      int nd = 0;
      int nb = 0;
      a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (3) tick;
      rst = 1'b1;
      tick;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0)
      begin n_fail++;
         $display("FAIL rstmid_outputs got busy=%b done=%b sum=%h cout=%b exp 0/0/00/0",
                  busy, done, sum, cout); end
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (done) nd++;
         if (busy) nb++;
         tick;
      end
      n_tests++;
      if (nd !== 0 || nb !== 0) begin n_fail++;
         $display("FAIL rstmid_quiet got done=%0d busy=%0d exp 0/0", nd, nb); end
   endtask

   task automatic test_random;
      logic [W-1:0] ra, rb, rs, s1;
      logic rsub, rc;
      logic [W:0] exp;
      int lat, nb, nd;
      for (int k = 0; k < 40; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (k == 0) begin ra = 8'hFF; rb = 8'hFF; end
         if (k == 1) begin ra = 8'h00; rb = 8'h00; end
         rsub = HAS_SUB ? 1'($urandom) : 1'b0;
         exp = model(ra, rb, rsub);
         do_op(ra, rb, rsub, rs, rc, lat, nb, nd, s1);
         n_tests++;
         if ({rc, rs} !== exp || lat !== 9 || nd !== 1 || nb !== 9) begin
            n_fail++;
            $display("FAIL rand_%0d a=%h b=%h sub=%b got %b_%h lat=%0d nd=%0d nb=%0d exp %b_%h/9/1/9",
                     k, ra, rb, rsub, rc, rs, lat, nd, nb, exp[W], exp[W-1:0]);
         end
      end
   endtask

   task automatic test_sub;
      logic [W-1:0] rs, s1;
      logic rc;
      int lat, nb, nd;
      do_op(8'h10, 8'h01, 1'b1, rs, rc, lat, nb, nd, s1);
      n_tests++;
      if ({rc, rs} !== 9'h10F || lat !== 9) begin n_fail++;
         $display("FAIL sub1 got %b_%h lat=%0d exp 1_0F/9", rc, rs, lat); end
      do_op(8'h01, 8'h02, 1'b1, rs, rc, lat, nb, nd, s1);
      n_tests++;
      if ({rc, rs} !== 9'h0FF || lat !== 9) begin n_fail++;
         $display("FAIL sub2 got %b_%h lat=%0d exp 0_FF/9", rc, rs, lat); end
      do_op(8'h35, 8'h4A, 1'b0, rs, rc, lat, nb, nd, s1);
      n_tests++;
      if ({rc, rs} !== 9'h07F) begin n_fail++;
         $display("FAIL sub0_add got %b_%h exp 0_7F", rc, rs); end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_start_held;
      test_ignore_busy;
      test_reset_mid;
      test_random;
      if (HAS_SUB) test_sub;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
